// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer so in_ready is a flop, not a path from out_ready.
// Optional performance counters are compiled in when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_reg #(
   parameter int XLEN = 32,
   parameter int ILEN = 32,
   parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h00000013),
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_pc4,
   input  logic [ILEN-1:0]  in_instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_pc4,
   output logic [ILEN-1:0]  out_instr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int PW = 2 * XLEN + ILEN;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   main_q, main_d;
   logic [PW-1:0]   skid_q, skid_d;
   logic            in_ready_q, in_ready_d;
   logic [PW-1:0]   in_pay;
   logic            in_xfer;
   logic            out_xfer;

   assign in_pay    = {in_pc, in_pc4, in_instr};
   assign out_valid = (state_q != S_EMPTY);
   assign in_ready  = in_ready_q;
   assign in_xfer   = in_valid && in_ready_q;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (in_xfer) begin
               state_d = S_ONE;
               main_d  = in_pay;
            end
         end
         S_ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_pay;
            end else if (in_xfer) begin
               state_d = S_FULL;
               skid_d  = in_pay;
            end else if (out_xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_xfer) begin
               state_d = S_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // Redirect wins: any same-cycle input is simply never latched as valid.
      if (flush) begin
         state_d = S_EMPTY;
      end
      in_ready_d = (state_d != S_FULL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Stale payload stays in MAIN, so the bubble values are forced at the port.
   assign out_pc    = out_valid ? main_q[PW-1 -: XLEN]        : '0;
   assign out_pc4   = out_valid ? main_q[ILEN+XLEN-1 -: XLEN] : '0;
   assign out_instr = out_valid ? main_q[ILEN-1:0]            : NOP_INSTR;

`ifdef IF_ID_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (out_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush && (state_q != S_EMPTY) && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/if_id_skid_reg.md
IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC and PC+4 width.
REQ-002 The block SHALL have parameter ILEN, default 32, meaning the instruction width.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the bubble instruction (addi x0,x0,0).
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning the performance counter width.
REQ-005 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-006 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-007 Port: reset  input  1  asynchronous, active-high reset.
REQ-008 Port: in_valid  input  1  fetch presents a valid instruction.
REQ-009 Port: in_ready  output  1  block accepts input this cycle.
REQ-010 Port: in_pc, in_pc4  input  XLEN each  fetched PC and PC+4.
REQ-011 Port: in_instr  input  ILEN  fetched instruction.
REQ-012 Port: flush  input  1  branch/jump redirect; kill all held entries.
REQ-013 Port: out_valid  output  1  decode-side entry valid.
REQ-014 Port: out_ready  input  1  decode accepts (deasserted on downstream busywait).
REQ-015 Port: out_pc, out_pc4  output  XLEN each  PC and PC+4 of head entry.
REQ-016 Port: out_instr  output  ILEN  instruction of head entry.
REQ-017 Port: stall_cnt, flush_cnt  output  CNT_W each  performance counters (see Configuration).

Function
REQ-018 Storage SHALL be two entries: MAIN (drives outputs) and SKID; each has a valid flag.
REQ-019 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-020 in_ready SHALL be a registered signal equal to !SKID.valid (no combinational in_ready path from out_ready).
REQ-021 out_valid SHALL equal MAIN.valid; latency input-to-output SHALL be exactly 1 cycle when MAIN is empty or drains in the same cycle.
REQ-022 Sustained throughput SHALL be one instruction per cycle while out_ready=1.
REQ-023 States: EMPTY (none valid), ONE (MAIN valid), FULL (both valid).
REQ-024 EMPTY: input transfer -> ONE, data to MAIN.
REQ-025 ONE: input and output transfer -> ONE with new data in MAIN; input only -> FULL, data to SKID; output only -> EMPTY.
REQ-026 FULL: output transfer -> ONE, SKID moves to MAIN; no input is accepted (in_ready=0).
REQ-027 Order SHALL be preserved; no entry SHALL be dropped or duplicated except by flush.
REQ-028 flush SHALL have priority over all transfers: next state EMPTY, and an input presented in the same cycle SHALL be discarded.
REQ-029 While out_valid=0, out_pc and out_pc4 SHALL be 0 and out_instr SHALL be NOP_INSTR.
REQ-030 Payload widths SHALL follow XLEN/ILEN exactly; there is no truncation or extension.

Reset
REQ-031 On reset assertion, state SHALL become EMPTY immediately and asynchronously, independent of clk.
REQ-032 Reset values: out_valid=0, in_ready=1, out_pc=0, out_pc4=0, out_instr=NOP_INSTR, stall_cnt=0, flush_cnt=0.
REQ-033 Reset mid-operation SHALL discard both entries; the first rising clk edge after deassertion SHALL obey REQ-024.

Configuration
REQ-034 Macro IF_ID_PERF_CNT_EN SHALL select whether the performance counters are compiled in.
REQ-035 With IF_ID_PERF_CNT_EN defined, stall_cnt SHALL increment each cycle with out_valid && !out_ready && !flush.
REQ-036 With IF_ID_PERF_CNT_EN defined, flush_cnt SHALL increment each cycle with flush=1 while in state ONE or FULL.
REQ-037 Both counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-038 Without IF_ID_PERF_CNT_EN, both counter outputs SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-039 Streaming: out_ready=1, feed pc=0x0,0x4,0x8 on consecutive cycles -> out_pc 0x0,0x4,0x8 on the following cycles, in_ready stays 1.
REQ-040 Backpressure: hold out_ready=0 with pc=0x10,0x14 offered -> FULL, in_ready=0, out_pc=0x10; raise out_ready -> out_pc 0x10 then 0x14, in_ready=1 one cycle after SKID drains.
REQ-041 Flush in FULL with in_valid=1 (pc=0x20) -> next cycle out_valid=0, out_instr=0x00000013, out_pc=0; 0x20 never appears; flush_cnt increments by 1 when IF_ID_PERF_CNT_EN is defined.
REQ-042 Async reset: assert reset between clk edges while FULL -> outputs reach their reset values before the next edge; stall_cnt=0.
REQ-043 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-044 Build without IF_ID_PERF_CNT_EN, rerun REQ-040 -> stall_cnt=flush_cnt=0 throughout and data behaviour is identical.
